// File: rtl/sram_mem_ctrl.sv
// ============================================================================
// Module  : sram_mem_ctrl
// Brief   : Moves 32-bit MEM-stage loads/stores over a 16-bit async SRAM
//           as two half-word phases, stalling the pipeline via ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_mem_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_LO   = 2'd1;
  localparam logic [1:0] c_S_HI   = 2'd2;
  localparam logic [1:0] c_S_DONE = 2'd3;

  localparam int                 c_CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_WAIT  = c_CNT_W'(WAIT_CYCLES);
  localparam logic [31:0]        c_BASE  = 32'(BASE_ADDR);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_write;

  logic               w_req;
  logic               w_phase_last;
  logic               w_write_op;
  logic [31:0]        w_offset;
  logic [ADDR_W-2:0]  w_word;
  logic               w_unused_bits;

  logic               w_ce_n;
  logic               w_oe_n;
  logic               w_we_n;
  logic               w_lane_n;
  logic               w_dq_oe;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_dq;

  assign w_req         = wr_en | rd_en;
  assign w_offset      = address - c_BASE;
  assign w_word        = w_offset[ADDR_W:2];
  assign w_unused_bits = &{1'b0, w_offset[31:ADDR_W+1], w_offset[1:0]};
  assign w_phase_last  = (r_cnt == c_WAIT);
  // Operation type is taken live on the IDLE->LO edge, latched afterwards.
  assign w_write_op    = (r_state == c_S_IDLE) ? wr_en : r_write;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: if (w_req)        w_next_state = c_S_LO;
      c_S_LO:   if (w_phase_last) w_next_state = c_S_HI;
      c_S_HI:   if (w_phase_last) w_next_state = c_S_DONE;
      default:                    w_next_state = c_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
    end else begin
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if (!w_phase_last) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      if ((r_state == c_S_IDLE) && w_req) begin
        r_write <= wr_en;
      end
    end
  end

  // SRAM pins are decoded from the next state so the registered copies line
  // up exactly with the LO/HI state cycles.
  always_comb begin
    ready    = (r_state == c_S_DONE) | ((r_state == c_S_IDLE) & ~w_req);
    w_ce_n   = 1'b1;
    w_oe_n   = 1'b1;
    w_we_n   = 1'b1;
    w_lane_n = 1'b1;
    w_dq_oe  = 1'b0;
    w_addr   = sram_addr;
    w_dq     = sram_dq_o;
    if ((w_next_state == c_S_LO) || (w_next_state == c_S_HI)) begin
      w_ce_n   = 1'b0;
      w_lane_n = 1'b0;
      w_oe_n   = w_write_op;
      w_we_n   = ~w_write_op;
      w_dq_oe  = w_write_op;
      w_addr   = {w_word, (w_next_state == c_S_HI)};
      w_dq     = (w_next_state == c_S_HI) ? write_data[31:16] : write_data[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      sram_addr  <= w_addr;
      sram_dq_o  <= w_dq;
      sram_dq_oe <= w_dq_oe;
      sram_ce_n  <= w_ce_n;
      sram_oe_n  <= w_oe_n;
      sram_we_n  <= w_we_n;
      sram_ub_n  <= w_lane_n;
      sram_lb_n  <= w_lane_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      read_data <= '0;
    end else if (!r_write && w_phase_last) begin
      if (r_state == c_S_LO) begin
        read_data[15:0] <= sram_dq_i;
      end
      if (r_state == c_S_HI) begin
        read_data[31:16] <= sram_dq_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_mem_ctrl.sv
// ============================================================================
// Module  : tb_sram_mem_ctrl
// Brief   : Bench for sram_mem_ctrl with an SRAM device model and a word-level
//           reference memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_mem_ctrl;

  localparam int ADDR_W      = 18;
  localparam int WAIT_CYCLES = 1;
  localparam int BASE_ADDR   = 1024;
  localparam int PH          = WAIT_CYCLES + 1;
  localparam int N_CYC       = 2 + 2 * PH;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [31:0]       address = '0;
  logic [31:0]       write_data = '0;
  logic [31:0]       read_data;
  logic              ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_o;
  logic [15:0]       sram_dq_i;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_ub_n;
  logic              sram_lb_n;

  int total = 0;
  int bad   = 0;

  bit   [15:0]  sram_mem [0:(1<<ADDR_W)-1];
  logic         pl_en = 1'b0;
  logic [17:0]  pl_addr = '0;
  logic [15:0]  pl_data = '0;

  logic [31:0]  ref_words [int unsigned];
  logic [31:0]  last_rd = '0;
  logic [40:0]  obs_q [0:N_CYC-1];
  logic [40:0]  exp_q [0:N_CYC-1];
  logic [31:0]  obs_rd;
  logic [31:0]  exp_rd;

  sram_mem_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(16), .WAIT_CYCLES(WAIT_CYCLES), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM device model
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0000;
  always @(posedge clk) begin
    if (pl_en) sram_mem[pl_addr] <= pl_data;
    else if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_dq_o;
  end

  function automatic logic [40:0] pack(input logic rdy, input logic ce, input logic oe,
                                       input logic we, input logic ub, input logic lb,
                                       input logic doe, input logic [17:0] a, input logic [15:0] d);
    return {rdy, ce, oe, we, ub, lb, doe, a, d};
  endfunction

  // Reference: one access = 1 request cycle, PH low-half cycles, PH high-half cycles, 1 done cycle.
  task automatic build_expect(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] off;
    int unsigned widx;
    logic [17:0] ha;
    logic [15:0] hd;
    off  = addr - 32'(BASE_ADDR);
    widx = (off / 4) % (1 << (ADDR_W - 1));
    for (int i = 0; i < N_CYC; i++) begin
      if (i == 0 || i == N_CYC - 1) begin
        exp_q[i] = pack(i != 0, 1, 1, 1, 1, 1, 0, 18'd0, 16'd0);
      end else begin
        ha = (i > PH) ? 18'(widx * 2 + 1) : 18'(widx * 2);
        hd = (i > PH) ? data[31:16] : data[15:0];
        exp_q[i] = pack(0, 0, wr, !wr, 0, 0, wr, ha, wr ? hd : 16'd0);
      end
    end
    if (wr) ref_words[widx] = data;
    else last_rd = ref_words.exists(widx) ? ref_words[widx] : 32'd0;
    exp_rd = last_rd;
  endtask

  // Starts and ends just after a rising edge; request stays asserted on exit.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data);
    build_expect(wr, addr, data);
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    for (int i = 0; i < N_CYC; i++) begin
      @(negedge clk);
      obs_q[i] = pack(ready, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                      sram_dq_oe, sram_ce_n ? 18'd0 : sram_addr,
                      sram_dq_oe ? sram_dq_o : 16'd0);
    end
    obs_rd = read_data;
    @(posedge clk); #1;
  endtask

  task automatic clear_req();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (read_data !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", read_data); end
    total++;
    if ({ready, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 7'b1111110) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=1111110",
               {ready, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe});
    end
    total++;
    if ({sram_addr, sram_dq_o} !== 34'd0) begin bad++; $display("FAIL reset_bus got=%h exp=0", {sram_addr, sram_dq_o}); end
    rst = 1'b1;
    last_rd = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    preload(18'd2, 16'hBEEF);
    preload(18'd3, 16'hDEAD);
    ref_words[1] = 32'hDEADBEEF;
    run_access(0, 1, 32'd1028, 32'h0);
    clear_req();
    for (int i = 0; i < N_CYC; i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL load cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++;
    if (obs_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", obs_rd); end
  endtask

  task automatic test_store();
    run_access(1, 0, 32'd1028, 32'hDEADBEEF);
    clear_req();
    for (int i = 0; i < N_CYC; i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL store cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++;
    if (sram_mem[2] !== 16'hBEEF || sram_mem[3] !== 16'hDEAD) begin
      bad++; $display("FAIL store_mem got=%h%h exp=deadbeef", sram_mem[3], sram_mem[2]);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    d = $urandom;
    run_access(1, 1, 32'd1036, d);
    clear_req();
    for (int i = 0; i < N_CYC; i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL prio cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++;
    if (obs_rd !== exp_rd) begin bad++; $display("FAIL prio_rdata got=%h exp=%h", obs_rd, exp_rd); end
  endtask

  task automatic test_reset_mid_op();
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1024 + 32'd4 * 32'd5000; write_data = 32'hA5A55A5A;
    repeat (2 + PH) @(negedge clk);
    total++;
    if (sram_we_n !== 1'b0) begin bad++; $display("FAIL midrst_hi got we_n=%b exp=0", sram_we_n); end
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    total++;
    if ({ready, sram_ce_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      bad++; $display("FAIL midrst_abort got=%b exp=1110", {ready, sram_ce_n, sram_we_n, sram_dq_oe});
    end
    rst = 1'b1;
    last_rd = '0;
    @(negedge clk);
    total++;
    if ({ready, sram_ce_n, read_data} !== {2'b11, 32'd0}) begin
      bad++; $display("FAIL midrst_idle got=%b_%b_%h exp=1_1_0", ready, sram_ce_n, read_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    run_access(1, 0, 32'd1032, d);
    for (int i = 0; i < N_CYC; i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_st cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    run_access(0, 1, 32'd1032, 32'h0);
    clear_req();
    for (int i = 0; i < N_CYC; i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_ld cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++;
    if (obs_rd !== d) begin bad++; $display("FAIL b2b_rdata got=%h exp=%h", obs_rd, d); end
  endtask

  task automatic test_random();
    logic        wr, rd;
    logic [31:0] a, d;
    int          op, gap;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      wr = (op != 1);
      rd = (op != 0);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'(BASE_ADDR) + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      d = $urandom;
      run_access(wr, rd, a, d);
      for (int i = 0; i < N_CYC; i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d cyc%0d got=%h exp=%h", n, i, obs_q[i], exp_q[i]); end
      end
      total++;
      if (obs_rd !== exp_rd) begin bad++; $display("FAIL rand%0d_rdata got=%h exp=%h", n, obs_rd, exp_rd); end
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        clear_req();
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          total++;
          if ({ready, sram_ce_n} !== 2'b11) begin bad++; $display("FAIL rand%0d_idle got=%b exp=11", n, {ready, sram_ce_n}); end
          @(posedge clk); #1;
        end
      end
    end
    clear_req();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_priority();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
